// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and PC alignment helper for the fetch sequencer.
package fetch_pkg;
  localparam int FETCH_WIDTH         = 64;
  localparam int FETCH_SLOTS         = 2;
  localparam int FETCH_SECTION_BYTES = 16;
  localparam int FETCH_MAX_OUT       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_seq_state_t;

  // Round a PC down to the start of its section; bytes must be a power of two.
  function automatic logic [FETCH_WIDTH-1:0] align_section(
    input logic [FETCH_WIDTH-1:0] pc,
    input int unsigned            bytes
  );
    logic [FETCH_WIDTH-1:0] mask;
    mask = FETCH_WIDTH'(bytes) - FETCH_WIDTH'(1);
    return pc & ~mask;
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its neighbours: redirect source,
// fetch engine and fetch buffer.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int WIDTH = FETCH_WIDTH,
  parameter int SLOTS = FETCH_SLOTS
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic             clkEn;
  logic             redirectValid;
  logic [WIDTH-1:0] redirectPc;
  logic             reqValid;
  logic             reqReady;
  logic [WIDTH-1:0] reqPc;
  logic             respValid;
  logic             slotWrEn;
  logic [IW-1:0]    slotWrIdx;
  logic [WIDTH-1:0] slotWrPc;
  logic             slotRelease;
  logic [SLOTS-1:0] slotValid;
  logic [IW-1:0]    headIdx;
  logic             preDecodeStall;

  modport master (
    input  clkEn, redirectValid, redirectPc, reqReady, respValid, slotRelease,
    output reqValid, reqPc, slotWrEn, slotWrIdx, slotWrPc, slotValid, headIdx,
           preDecodeStall
  );

  modport slave (
    output clkEn, redirectValid, redirectPc, reqReady, respValid, slotRelease,
    input  reqValid, reqPc, slotWrEn, slotWrIdx, slotWrPc, slotValid, headIdx,
           preDecodeStall
  );
endinterface

// File: rtl/fetch_sequencer_slot_tracker.sv
// Fetch buffer occupancy: head/tail pointers, per-slot valid bits and free count.
module slot_tracker
  import fetch_pkg::*;
#(
  parameter  int SLOTS = FETCH_SLOTS,
  localparam int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int CW    = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             rel_req,
  output logic [SLOTS-1:0] valid,
  output logic [IW-1:0]    head,
  output logic [IW-1:0]    tail,
  output logic [CW-1:0]    free,
  output logic             stall
);
  logic [SLOTS-1:0] valid_reg, valid_next;
  logic [IW-1:0]    head_reg, head_next;
  logic [IW-1:0]    tail_reg, tail_next;
  logic [CW-1:0]    used;
  logic             rel_ok;

  assign rel_ok = rel_req && valid_reg[head_reg];

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic set_bit;
      logic clr_bit;
      assign set_bit = wr_en && (tail_reg == IW'(gi));
      assign clr_bit = rel_ok && (head_reg == IW'(gi));
      // Write beats a release of the same slot; a flush beats everything.
      assign valid_next[gi] = flush ? 1'b0 : (set_bit | (valid_reg[gi] & ~clr_bit));
    end
  endgenerate

  assign head_next = flush ? '0 : head_reg + IW'(rel_ok);
  assign tail_next = flush ? '0 : tail_reg + IW'(wr_en);

  always_comb begin
    used = '0;
    for (int i = 0; i < SLOTS; i++) begin
      used = used + CW'(valid_reg[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  assign free  = CW'(SLOTS) - used;
  assign valid = valid_reg;
  assign head  = head_reg;
  assign tail  = tail_reg;
  assign stall = !valid_reg[head_reg];
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch buffer sequencer: issues section requests against buffer credit,
// steers returning sections into slots and drains stale requests after a redirect.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int WIDTH         = FETCH_WIDTH,
  parameter int SLOTS         = FETCH_SLOTS,
  parameter int SECTION_BYTES = FETCH_SECTION_BYTES,
  parameter int MAX_OUT       = FETCH_MAX_OUT
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW = $clog2(SLOTS + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [1:0]       S_IDLE  = IDLE;
  localparam logic [1:0]       S_RUN   = RUN;
  localparam logic [1:0]       S_DRAIN = DRAIN;
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(SECTION_BYTES);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [OW-1:0]    outstanding_reg, outstanding_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [WIDTH-1:0] pc_fifo [MAX_OUT];

  logic [CW-1:0]    free;
  logic [IW-1:0]    tail;
  logic [WIDTH-1:0] redirect_aligned;
  logic             issue, resp_take, wr_en, flush, rel_req;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUT - 1) ? '0 : p + PW'(1);
  endfunction

  assign redirect_aligned = WIDTH'(align_section(FETCH_WIDTH'(bus.redirectPc), SECTION_BYTES));

  assign bus.reqValid = (state_reg == S_RUN) && bus.clkEn && !bus.redirectValid
                        && (32'(outstanding_reg) < MAX_OUT)
                        && (32'(outstanding_reg) < 32'(free));
  assign bus.reqPc    = fetch_pc_reg;

  assign issue     = bus.reqValid && bus.reqReady;
  // Responses with nothing in flight belong to a pre-reset request and are ignored.
  assign resp_take = bus.clkEn && bus.respValid && (outstanding_reg != '0);
  assign wr_en     = resp_take && (state_reg == S_RUN) && !bus.redirectValid;
  assign flush     = bus.clkEn && bus.redirectValid && (state_reg == S_RUN);
  assign rel_req   = bus.clkEn && bus.slotRelease;

  assign bus.slotWrEn  = wr_en;
  assign bus.slotWrIdx = tail;
  assign bus.slotWrPc  = pc_fifo[rd_ptr_reg];

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    outstanding_next = outstanding_reg + OW'(issue) - OW'(resp_take);
    if (issue) begin
      fetch_pc_next = fetch_pc_reg + STEP;
      wr_ptr_next   = ptr_inc(wr_ptr_reg);
    end
    if (resp_take) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    if (bus.clkEn) begin
      case (state_reg)
        S_IDLE: begin
          if (bus.redirectValid) begin
            fetch_pc_next = redirect_aligned;
            state_next    = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.redirectValid) begin
            fetch_pc_next = redirect_aligned;
            state_next    = (outstanding_next != '0) ? S_DRAIN : S_RUN;
          end
        end
        S_DRAIN: begin
          if (bus.redirectValid) begin
            fetch_pc_next = redirect_aligned;
          end
          if (outstanding_next == '0) begin
            state_next = S_RUN;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      fetch_pc_reg    <= '0;
      outstanding_reg <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // PC of each issued request, read back in order when its section returns.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_fifo[wr_ptr_reg] <= fetch_pc_reg;
    end
  end

  slot_tracker #(
    .SLOTS (SLOTS)
  ) u_slot_tracker (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .rel_req (rel_req),
    .valid   (bus.slotValid),
    .head    (bus.headIdx),
    .tail    (tail),
    .free    (free),
    .stall   (bus.preDecodeStall)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by random traffic.
module tb_fetch_sequencer;
  localparam int W  = 64;
  localparam int SL = 2;
  localparam int SB = 16;
  localparam int MO = 2;

  logic clk;
  logic rst;

  fetch_sequencer_if #(.WIDTH(W), .SLOTS(SL)) bus ();

  fetch_sequencer #(
    .WIDTH         (W),
    .SLOTS         (SL),
    .SECTION_BYTES (SB),
    .MAX_OUT       (MO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pc;
    bit          stale;
  } fl_t;

  typedef struct {
    int          cyc;
    logic [63:0] pc;
    int          idx;
  } ev_t;

  typedef struct {
    logic [SL-1:0] valid;
    int            head;
    bit            stall;
  } st_t;

  // Reference model: in-flight requests, buffer occupancy and fetch PC.
  fl_t         infl[$];
  bit          m_started;
  logic [63:0] m_pc;
  int          m_head;
  int          m_cnt;

  ev_t req_q[$];
  ev_t wr_q[$];
  st_t sts_q[$];

  int checks  = 0;
  int errors  = 0;
  int cur_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cur_cyc);
    end
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit r, input bit ce, input bit rv, input logic [63:0] rpc,
                      input bit rdy, input bit resp, input bit rel);
    int            free;
    bit            blocked, run, req, take, wr, rel_ok;
    logic [SL-1:0] vbits;
    @(posedge clk);
    #1;
    cur_cyc++;
    rst               = r;
    bus.clkEn         = ce;
    bus.redirectValid = rv;
    bus.redirectPc    = rpc;
    bus.reqReady      = rdy;
    bus.respValid     = resp;
    bus.slotRelease   = rel;
    if (r) begin
      m_started = 1'b0;
      m_pc      = '0;
      m_head    = 0;
      m_cnt     = 0;
      infl.delete();
    end
    free    = SL - m_cnt;
    blocked = 1'b0;
    foreach (infl[i]) if (infl[i].stale) blocked = 1'b1;
    run  = m_started && !blocked;
    req  = !r && ce && run && !rv && (infl.size() < MO) && (infl.size() < free);
    take = !r && ce && resp && (infl.size() > 0);
    wr   = take && run && !rv;
    if (req) req_q.push_back('{cyc: cur_cyc, pc: m_pc, idx: 0});
    if (wr)  wr_q.push_back('{cyc: cur_cyc, pc: infl[0].pc, idx: (m_head + m_cnt) % SL});
    vbits = '0;
    for (int k = 0; k < m_cnt; k++) vbits[(m_head + k) % SL] = 1'b1;
    sts_q.push_back('{valid: vbits, head: m_head, stall: (m_cnt == 0)});
    if (!r && ce) begin
      rel_ok = rel && (m_cnt > 0);
      if (take) void'(infl.pop_front());
      if (rel_ok) begin
        m_head = (m_head + 1) % SL;
        m_cnt--;
      end
      if (wr) m_cnt++;
      if (req && rdy) begin
        infl.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 64'(SB);
      end
      if (rv) begin
        m_pc = rpc - (rpc % 64'(SB));
        if (!m_started) begin
          m_started = 1'b1;
        end else if (run) begin
          m_head = 0;
          m_cnt  = 0;
          foreach (infl[i]) infl[i].stale = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    bit  exp_p;
    ev_t e;
    st_t s;
    exp_p = (req_q.size() > 0) && (req_q[0].cyc == cur_cyc);
    chk("req_valid", 64'(bus.reqValid), 64'(exp_p));
    if (exp_p) begin
      e = req_q.pop_front();
      if (bus.reqValid) chk("req_pc", bus.reqPc, e.pc);
    end
    exp_p = (wr_q.size() > 0) && (wr_q[0].cyc == cur_cyc);
    chk("wr_en", 64'(bus.slotWrEn), 64'(exp_p));
    if (exp_p) begin
      e = wr_q.pop_front();
      if (bus.slotWrEn) begin
        chk("wr_idx", 64'(bus.slotWrIdx), 64'(e.idx));
        chk("wr_pc", bus.slotWrPc, e.pc);
        $display("write cyc=%0d slot=%0d pc=0x%0h", cur_cyc, bus.slotWrIdx, bus.slotWrPc);
      end
    end
    if (sts_q.size() > 0) begin
      s = sts_q.pop_front();
      chk("slot_valid", 64'(bus.slotValid), 64'(s.valid));
      chk("head_idx", 64'(bus.headIdx), 64'(s.head));
      chk("stall", 64'(bus.preDecodeStall), 64'(s.stall));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b1;
    bus.clkEn         = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectPc    = '0;
    bus.reqReady      = 1'b0;
    bus.respValid     = 1'b0;
    bus.slotRelease   = 1'b0;

    // Reset and boot at 0x1009.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_req_valid", 64'(bus.reqValid), 64'd0);
    chk("rst_stall", 64'(bus.preDecodeStall), 64'd1);
    step(0, 1, 0, 0, 1, 0, 0);
    #1 chk("idle_req_valid", 64'(bus.reqValid), 64'd0);
    step(0, 1, 1, 64'h1009, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    #1 chk("boot_pc0", bus.reqPc, 64'h1000);
    step(0, 1, 0, 0, 1, 0, 0);
    #1 chk("boot_pc1", bus.reqPc, 64'h1010);
    step(0, 1, 0, 0, 1, 0, 0);
    #1 chk("credit_block", 64'(bus.reqValid), 64'd0);

    // Fill both slots, then consume one.
    step(0, 1, 0, 0, 0, 1, 0);
    #1 chk("fill0_pc", bus.slotWrPc, 64'h1000);
    step(0, 1, 0, 0, 0, 1, 0);
    #1 chk("fill1_idx", 64'(bus.slotWrIdx), 64'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    #1 chk("full_valid", 64'(bus.slotValid), 64'h3);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    #1 chk("after_rel_head", 64'(bus.headIdx), 64'd1);

    // Backpressure holds reqPc.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      #1 chk("bp_pc", bus.reqPc, 64'h1020);
    end
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 1, 0, 0);

    // Redirect with two in flight: drain, then restart at 0x2000.
    step(0, 1, 1, 64'h2000, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    #1 chk("drain_no_write", 64'(bus.slotWrEn), 64'd0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    #1 chk("restart_pc", bus.reqPc, 64'h2000);

    // Redirect with response drops the write; issue with response keeps the count.
    step(0, 1, 1, 64'h3004, 1, 1, 0);
    #1 chk("redir_resp_no_write", 64'(bus.slotWrEn), 64'd0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    #1 chk("issue_resp_pc", bus.reqPc, 64'h3010);
    step(0, 1, 0, 0, 1, 0, 0);
    #1 chk("count_unchanged", 64'(bus.reqValid), 64'd0);

    // Asynchronous reset while draining.
    step(0, 1, 1, 64'h4000, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("async_rst_valid", 64'(bus.slotValid), 64'd0);
    chk("async_rst_stall", 64'(bus.preDecodeStall), 64'd1);
    step(1, 0, 0, 0, 0, 0, 0);

    // Random traffic, including PC wrap and spurious responses.
    for (int n = 0; n < 1500; n++) begin
      bit          ce, rv, rdy, resp, rel;
      logic [63:0] rpc;
      if ($urandom_range(0, 399) == 0) begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
      end else begin
        ce   = ($urandom_range(0, 7) != 0);
        rdy  = ($urandom_range(0, 3) != 0);
        rv   = 1'b0;
        resp = 1'b0;
        rel  = 1'b0;
        rpc  = '0;
        if (ce) begin
          rv   = ($urandom_range(0, 15) == 0);
          resp = (infl.size() > 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0);
          rel  = ($urandom_range(0, 2) == 0);
          rpc  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFE7 : {$urandom, $urandom};
        end
        step(0, ce, rv, rpc, rdy, resp, rel);
      end
    end
    step(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
